// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search engine.
package sar_pkg;

    localparam int unsigned GENISLIK_VARSAYILAN = 3;

    typedef enum logic [1:0] {
        BOS,
        DENE,
        BITTI
    } durum_e;

endpackage

// File: rtl/sar_arayici.sv
// MSB-first successive-approximation search against an external ">=" comparator.
// Presents a trial value each cycle and reports the recovered value once all bits are decided.
module sar_arayici
    import sar_pkg::*;
#(
    parameter int unsigned GENISLIK = GENISLIK_VARSAYILAN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                basla,
    input  logic                karsilastirma,
    input  logic                karsilastirma_gecerli,
    output logic [GENISLIK-1:0] deneme,
    output logic [GENISLIK-1:0] sonuc,
    output logic                hazir,
    output logic                mesgul
);

    localparam int unsigned PW = (GENISLIK > 1) ? $clog2(GENISLIK) : 1;
    localparam logic [PW-1:0] PTR_MSB = PW'(GENISLIK - 1);
    localparam logic [GENISLIK-1:0] ILK_DENEME = {1'b1, {(GENISLIK - 1){1'b0}}};

    durum_e              durum_q, durum_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       ptr_m1;
    logic [GENISLIK-1:0] deneme_q, deneme_d;
    logic [GENISLIK-1:0] sonuc_q, sonuc_d;
    logic [GENISLIK-1:0] yeni;

    assign ptr_m1 = ptr_q - PW'(1);

    always_comb begin
        durum_d  = durum_q;
        ptr_d    = ptr_q;
        deneme_d = deneme_q;
        sonuc_d  = sonuc_q;
        yeni     = deneme_q;
        unique case (durum_q)
            BOS: begin
                if (basla) begin
                    durum_d  = DENE;
                    deneme_d = ILK_DENEME;
                    ptr_d    = PTR_MSB;
                end else begin
                    deneme_d = '0;
                end
            end
            DENE: begin
                // Without a valid comparator result everything holds, for as long as it takes.
                if (karsilastirma_gecerli) begin
                    yeni[ptr_q] = karsilastirma;
                    if (ptr_q != '0) begin
                        yeni[ptr_m1] = 1'b1;
                        ptr_d        = ptr_m1;
                    end else begin
                        sonuc_d = yeni;
                        durum_d = BITTI;
                    end
                    deneme_d = yeni;
                end
            end
            BITTI: begin
                durum_d  = BOS;
                deneme_d = '0;
            end
            default: begin
                durum_d  = BOS;
                deneme_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_q  <= BOS;
            ptr_q    <= PTR_MSB;
            deneme_q <= '0;
            sonuc_q  <= '0;
        end else begin
            durum_q  <= durum_d;
            ptr_q    <= ptr_d;
            deneme_q <= deneme_d;
            sonuc_q  <= sonuc_d;
        end
    end

    assign deneme = deneme_q;
    assign sonuc  = sonuc_q;
    assign hazir  = (durum_q == BITTI);
    assign mesgul = (durum_q == DENE);

endmodule

// File: tb/tb_sar_arayici.sv
// Directed bench for sar_arayici with a behavioural >= comparator closing the loop.
module tb_sar_arayici;

    logic       clk = 1'b0;
    logic       rst;
    logic       basla;
    logic       karsilastirma;
    logic       karsilastirma_gecerli;
    logic [2:0] deneme;
    logic [2:0] sonuc;
    logic       hazir;
    logic       mesgul;
    logic [2:0] bilinmeyen;

    int checks   = 0;
    int failures = 0;

    sar_arayici #(.GENISLIK(3)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .basla                 (basla),
        .karsilastirma         (karsilastirma),
        .karsilastirma_gecerli (karsilastirma_gecerli),
        .deneme                (deneme),
        .sonuc                 (sonuc),
        .hazir                 (hazir),
        .mesgul                (mesgul)
    );

    always #5 clk = ~clk;

    assign karsilastirma = (bilinmeyen >= deneme);

    // Advance one rising edge and land on the following falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; basla = 1'b0; karsilastirma_gecerli = 1'b0; bilinmeyen = 3'd0;
        #2;
        checks++;
        if ({deneme, sonuc, hazir, mesgul} !== 8'h00) begin
            failures++;
            $display("FAIL reset: deneme=%b sonuc=%b hazir=%b mesgul=%b required all 0",
                     deneme, sonuc, hazir, mesgul);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if ({deneme, hazir, mesgul} !== 5'b0) begin
            failures++;
            $display("FAIL idle_after_reset: deneme=%b hazir=%b mesgul=%b required 0",
                     deneme, hazir, mesgul);
        end
    endtask

    // Full search with gecerli tied high; trials and result are hand-computed by the caller.
    task automatic test_search(input string ad, input logic [2:0] deger,
                               input logic [2:0] d0, input logic [2:0] d1,
                               input logic [2:0] d2, input logic [2:0] beklenen);
        logic [2:0] exp_d [3];
        exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2;
        bilinmeyen = deger; karsilastirma_gecerli = 1'b1; basla = 1'b1;
        tick();
        basla = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (deneme !== exp_d[i] || mesgul !== 1'b1 || hazir !== 1'b0) begin
                failures++;
                $display("FAIL %s_trial%0d: deneme=%b mesgul=%b hazir=%b required %b 1 0",
                         ad, i, deneme, mesgul, hazir, exp_d[i]);
            end
            tick();
        end
        checks++;
        if (sonuc !== beklenen || hazir !== 1'b1 || mesgul !== 1'b0 || deneme !== beklenen) begin
            failures++;
            $display("FAIL %s_done: sonuc=%b hazir=%b mesgul=%b deneme=%b required %b 1 0 %b",
                     ad, sonuc, hazir, mesgul, deneme, beklenen, beklenen);
        end
        tick();
        checks++;
        if (hazir !== 1'b0 || deneme !== 3'b000 || sonuc !== beklenen) begin
            failures++;
            $display("FAIL %s_back_idle: hazir=%b deneme=%b sonuc=%b required 0 000 %b",
                     ad, hazir, deneme, sonuc, beklenen);
        end
    endtask

    task automatic test_stall();
        logic [2:0] exp_d [4];
        exp_d[0] = 3'b100; exp_d[1] = 3'b110; exp_d[2] = 3'b111; exp_d[3] = 3'b110;
        bilinmeyen = 3'd6; karsilastirma_gecerli = 1'b1; basla = 1'b1;
        tick();
        basla = 1'b0;
        for (int i = 0; i < 3; i++) begin
            karsilastirma_gecerli = 1'b0;
            for (int j = 0; j < 2; j++) begin
                tick();
                checks++;
                if (deneme !== exp_d[i] || mesgul !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_hold%0d_%0d: deneme=%b mesgul=%b required %b 1",
                             i, j, deneme, mesgul, exp_d[i]);
                end
            end
            karsilastirma_gecerli = 1'b1;
            tick();
        end
        checks++;
        if (sonuc !== 3'b110 || hazir !== 1'b1 || deneme !== exp_d[3]) begin
            failures++;
            $display("FAIL stall_done: sonuc=%b hazir=%b deneme=%b required 110 1 110",
                     sonuc, hazir, deneme);
        end
        tick();
    endtask

    task automatic test_basla_held();
        logic [2:0] exp_d [5];
        exp_d[0] = 3'b100; exp_d[1] = 3'b010; exp_d[2] = 3'b011;
        exp_d[3] = 3'b010; exp_d[4] = 3'b000;
        bilinmeyen = 3'd2; karsilastirma_gecerli = 1'b1; basla = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (deneme !== exp_d[i]) begin
                failures++;
                $display("FAIL held_edge%0d: deneme=%b required %b", i, deneme, exp_d[i]);
            end
        end
        checks++;
        if (sonuc !== 3'b010 || mesgul !== 1'b0) begin
            failures++;
            $display("FAIL held_single: sonuc=%b mesgul=%b required 010 0", sonuc, mesgul);
        end
        tick();
        checks++;
        if (mesgul !== 1'b1 || deneme !== 3'b100) begin
            failures++;
            $display("FAIL held_restart: mesgul=%b deneme=%b required 1 100", mesgul, deneme);
        end
        basla = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(negedge clk);
        bilinmeyen = 3'd5; karsilastirma_gecerli = 1'b1; basla = 1'b1;
        tick();
        basla = 1'b0;
        tick();
        checks++;
        if (deneme !== 3'b110 || mesgul !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: deneme=%b mesgul=%b required 110 1", deneme, mesgul);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({deneme, sonuc, hazir, mesgul} !== 8'h00) begin
            failures++;
            $display("FAIL mid_async: deneme=%b sonuc=%b hazir=%b mesgul=%b required all 0",
                     deneme, sonuc, hazir, mesgul);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (hazir !== 1'b0 || mesgul !== 1'b0 || sonuc !== 3'b000) begin
                failures++;
                $display("FAIL mid_quiet%0d: hazir=%b mesgul=%b sonuc=%b required 0 0 000",
                         i, hazir, mesgul, sonuc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_search("v5", 3'd5, 3'b100, 3'b110, 3'b101, 3'b101);
        test_search("v0", 3'd0, 3'b100, 3'b010, 3'b001, 3'b000);
        test_search("v7", 3'd7, 3'b100, 3'b110, 3'b111, 3'b111);
        test_search("v3", 3'd3, 3'b100, 3'b010, 3'b011, 3'b011);
        test_stall();
        test_basla_held();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
